spike_rate_decoder: RTL

Rate decoder at the output side of the time-multiplexed LIF neuron array. Consumes the one-bit spike stream with its slot index, counts spikes per neuron over a fixed window of enabled cycles, and publishes one saturating 8-bit rate per neuron at each window boundary. Converts spike trains back into 8-bit magnitudes comparable to the neuron input current. Feeds downstream readout or the next layer.

---
 rtl/spike_pkg.sv | 19 +
 rtl/sat_counter.sv | 37 +++
 rtl/spike_rate_decoder.sv | 91 +++++++++
 3 files changed

// File: rtl/spike_pkg.sv
// Shared definitions for the LIF neuron array and its rate decoder:
// default sizes, the published-rate vector type and a saturating increment.
package spike_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int SEL_W       = 2;
    localparam int CNT_W       = 8;

    typedef logic [CNT_W-1:0]          rate_t;
    typedef rate_t [NUM_NEURONS-1:0]   rate_vec_t;

    // Increment v by one, clipping at max. Operates on a 16-bit container so
    // any counter up to 16 bits can share it by zero-extending.
    function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                            input logic [15:0] max);
        return (v >= max) ? max : v + 16'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-neuron spike counter. Saturates at all-ones; nxt_o exposes the value
// the counter would take this cycle so the top can publish it on the
// closing cycle while the counter itself clears.
module sat_counter
    import spike_pkg::*;
#(
    parameter int CNT_W = spike_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] nxt_o,
    output logic             sat_o
);

    localparam logic [15:0] MAX = 16'((32'd1 << CNT_W) - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      inc_val;

    // Saturating next value; sat_o flags an increment that lands on or is
    // clipped at the maximum.
    always_comb begin
        inc_val = sat_inc(16'(cnt_q), MAX);
        nxt_o   = inc_i ? inc_val[CNT_W-1:0] : cnt_q;
        sat_o   = inc_i && (inc_val == MAX);
        cnt_d   = clr_i ? '0 : nxt_o;
    end

    // Counter register; clear wins over increment at a window close.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per neuron over WINDOW enabled cycles and
// publishes a saturating rate per neuron at each window boundary.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int NUM_NEURONS = spike_pkg::NUM_NEURONS,
    parameter int SEL_W       = spike_pkg::SEL_W,
    parameter int CNT_W       = spike_pkg::CNT_W,
    parameter int WINDOW      = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_valid,
    input  logic             spike,
    input  logic [SEL_W-1:0] slot,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             sat_flag,
    output logic [15:0]      win_pos
);

    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

    logic [15:0]                        win_q, win_d;
    logic                               close;
    logic [NUM_NEURONS-1:0]             inc;
    logic [NUM_NEURONS-1:0]             sat_ev;
    logic [NUM_NEURONS-1:0][CNT_W-1:0]  nxt;
    logic [NUM_NEURONS-1:0][CNT_W-1:0]  rate_q, rate_d;
    logic                               sat_win_q, sat_win_d;
    logic                               sat_flag_q, sat_flag_d;
    logic                               vld_q;

    // Decode the slot into one increment strobe; at most one is high.
    always_comb begin
        close = en && (win_q == WIN_LAST);
        for (int i = 0; i < NUM_NEURONS; i++)
            inc[i] = en && spike_valid && spike && (slot == SEL_W'(i));
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (inc[g]),
            .clr_i (close),
            .nxt_o (nxt[g]),
            .sat_o (sat_ev[g])
        );
    end

    // Next state for timer, window sat bit and published registers. The
    // closing cycle's increment is already folded into nxt and sat_ev.
    always_comb begin
        win_d      = win_q;
        sat_win_d  = sat_win_q | (|sat_ev);
        sat_flag_d = sat_flag_q;
        rate_d     = rate_q;
        if (en) win_d = close ? 16'd0 : win_q + 16'd1;
        if (close) begin
            rate_d     = nxt;
            sat_flag_d = sat_win_q | (|sat_ev);
            sat_win_d  = 1'b0;
        end
    end

    // State registers; reset discards any partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            sat_win_q  <= 1'b0;
            sat_flag_q <= 1'b0;
            rate_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            win_q      <= win_d;
            sat_win_q  <= sat_win_d;
            sat_flag_q <= sat_flag_d;
            rate_q     <= rate_d;
            vld_q      <= close;
        end
    end

    assign rate_out   = rate_q[rd_sel];
    assign rate_valid = vld_q;
    assign sat_flag   = sat_flag_q;
    assign win_pos    = win_q;

endmodule
